vga_text_renderer: RTL and testbench

- Downstream of the VGA timing generator; consumes its pixel coordinates, syncs and display-enable.
- Renders an 800x600 text screen of 100x75 cells, each 8x8 pixels.
- Fetches each cell's character/attribute word from VRAM, then the glyph row from the font ROM, then applies a 16-colour palette and a blinking cursor.
- Outputs RGB with HS/VS re-aligned to the pixel pipeline.

---
 rtl/vga_text_pkg.sv | 57 +++++
 rtl/vga_text_renderer_if.sv | 10 +
 rtl/text_palette.sv | 10 +
 rtl/vga_text_renderer.sv | 117 +++++++++++
 tb/tb_vga_text_renderer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants, VRAM word layout, stage records and palette for the text renderer
package vga_text_pkg;
    localparam int COLS    = 100;
    localparam int ROWS    = 75;
    localparam int LATENCY = 4;

    // VRAM word: [7:0] char code, [11:8] fg index, [15:12] bg index
    localparam int CHAR_LSB = 0;
    localparam int CHAR_W   = 8;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;
    localparam int IDX_W    = 4;

    // CGA-style palette, entry 0 in the low 12 bits
    localparam logic [15:0][11:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55, 12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00, 12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };

    // cursor/pixel info carried from the coordinate stage to the VRAM-sample stage
    typedef struct packed {
        logic       hit;
        logic [2:0] px;
        logic [2:0] py;
    } carry_t;

    typedef struct packed {
        logic [12:0] vram_addr;
        carry_t      c;
    } fetch_t;

    // colour selection info carried to the final stage
    typedef struct packed {
        logic [IDX_W-1:0] fg;
        logic [IDX_W-1:0] bg;
        logic             hit;
        logic [2:0]       px;
    } shade_t;

    typedef struct packed {
        logic [10:0] font_addr;
        shade_t      sh;
    } glyph_t;

    // row*cols as a sum of shifted copies of row, one per set bit of cols;
    // for 100 this is (row<<6)+(row<<5)+(row<<2)
    function automatic logic [12:0] times_cols(input logic [7:0] row, input int cols);
        logic [12:0] acc;
        acc = '0;
        for (int i = 0; i < 7; i++) begin
            if (cols[i]) begin
                acc = acc + (13'(row) << i);
            end
        end
        return acc;
    endfunction
endpackage

// File: rtl/vga_text_renderer_if.sv
// rtl/vga_text_renderer_if.sv - VRAM and font ROM read bus between renderer (master) and memories (slave)
interface vga_text_renderer_if;
    logic [12:0] VRAM_ADDR;
    logic [15:0] VRAM_DATA;
    logic [10:0] FONT_ADDR;
    logic [7:0]  FONT_DATA;

    modport master (output VRAM_ADDR, output FONT_ADDR, input VRAM_DATA, input FONT_DATA);
    modport slave  (input VRAM_ADDR, input FONT_ADDR, output VRAM_DATA, output FONT_DATA);
endinterface

// File: rtl/text_palette.sv
// rtl/text_palette.sv - combinational 4-bit colour index to 12-bit RGB lookup
// Ports: idx (palette index in), rgb ({R,G,B} out, 4 bits each).
module text_palette
    import vga_text_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [11:0]      rgb
);
    assign rgb = PALETTE[idx];
endmodule

// File: rtl/vga_text_renderer.sv
// rtl/vga_text_renderer.sv - 100x75 cell, 8x8 glyph text renderer with palette and blinking cursor
// Ports: CLK_PIXEL/RESET_N (clock, async active-low reset); SCREEN_X/Y coordinates;
//        HS_IN/VS_IN/DE_IN timing (one cycle behind coordinates); CURSOR_X/Y/EN;
//        mem (VRAM and font ROM read bus, master side); R/G/B/HS/VS aligned outputs.
module vga_text_renderer #(
    parameter int COLS      = vga_text_pkg::COLS,
    parameter int ROWS      = vga_text_pkg::ROWS,
    parameter int BLINK_BIT = 4
) (
    input  logic                        CLK_PIXEL,
    input  logic                        RESET_N,
    input  logic [10:0]                 SCREEN_X,
    input  logic [10:0]                 SCREEN_Y,
    input  logic                        HS_IN,
    input  logic                        VS_IN,
    input  logic                        DE_IN,
    input  logic [6:0]                  CURSOR_X,
    input  logic [6:0]                  CURSOR_Y,
    input  logic                        CURSOR_EN,
    vga_text_renderer_if.master         mem,
    output logic [3:0]                  R,
    output logic [3:0]                  G,
    output logic [3:0]                  B,
    output logic                        HS,
    output logic                        VS
);
    import vga_text_pkg::*;

    logic [7:0]  col;
    logic [7:0]  row;
    logic        in_range;
    logic        glyph_bit;
    logic        swap;
    logic [IDX_W-1:0] pal_idx;
    logic [11:0] pal_rgb;

    fetch_t s1_q, s1_d;     // after coordinate edge
    carry_t s2_q, s2_d;     // while VRAM read is in flight
    glyph_t s3_q, s3_d;     // after VRAM sample
    shade_t s4_q, s4_d;     // while font read is in flight
    logic [11:0] rgb_q, rgb_d;
    // syncs enter one cycle late, so LATENCY flops realign them with RGB;
    // DE only needs to reach the colour mux, one flop earlier
    logic [LATENCY-1:0] hs_pipe_q, hs_pipe_d;
    logic [LATENCY-1:0] vs_pipe_q, vs_pipe_d;
    logic [LATENCY-2:0] de_pipe_q, de_pipe_d;
    logic [4:0]  frame_q, frame_d;

    text_palette u_palette (
        .idx (pal_idx),
        .rgb (pal_rgb)
    );

    always_comb begin
        col      = SCREEN_X[10:3];
        row      = SCREEN_Y[10:3];
        in_range = (int'(col) < COLS) && (int'(row) < ROWS);

        s1_d.vram_addr = in_range ? (times_cols(row, COLS) + 13'(col)) : 13'd0;
        s1_d.c.hit     = in_range & CURSOR_EN & (col == {1'b0, CURSOR_X}) & (row == {1'b0, CURSOR_Y});
        s1_d.c.px      = SCREEN_X[2:0];
        s1_d.c.py      = SCREEN_Y[2:0];

        s2_d = s1_q.c;

        s3_d.font_addr = {mem.VRAM_DATA[CHAR_LSB +: CHAR_W], s2_q.py};
        s3_d.sh.fg     = mem.VRAM_DATA[FG_LSB +: IDX_W];
        s3_d.sh.bg     = mem.VRAM_DATA[BG_LSB +: IDX_W];
        s3_d.sh.hit    = s2_q.hit;
        s3_d.sh.px     = s2_q.px;

        s4_d = s3_q.sh;

        // cursor blink inverts the glyph bit, i.e. swaps fg and bg
        glyph_bit = mem.FONT_DATA[3'd7 - s4_q.px];
        swap      = s4_q.hit & frame_q[BLINK_BIT];
        pal_idx   = (glyph_bit ^ swap) ? s4_q.fg : s4_q.bg;
        rgb_d     = de_pipe_q[LATENCY-2] ? pal_rgb : 12'h000;

        hs_pipe_d = {hs_pipe_q[LATENCY-2:0], HS_IN};
        vs_pipe_d = {vs_pipe_q[LATENCY-2:0], VS_IN};
        de_pipe_d = {de_pipe_q[LATENCY-3:0], DE_IN};

        // vs_pipe_q[0] is last cycle's VS_IN, giving a registered rising-edge detect
        frame_d = frame_q + ((VS_IN & ~vs_pipe_q[0]) ? 5'd1 : 5'd0);
    end

    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            s4_q      <= '0;
            rgb_q     <= '0;
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            de_pipe_q <= '0;
            frame_q   <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            s4_q      <= s4_d;
            rgb_q     <= rgb_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            de_pipe_q <= de_pipe_d;
            frame_q   <= frame_d;
        end
    end

    assign mem.VRAM_ADDR = s1_q.vram_addr;
    assign mem.FONT_ADDR = s3_q.font_addr;
    assign {R, G, B}     = rgb_q;
    assign HS            = hs_pipe_q[LATENCY-1];
    assign VS            = vs_pipe_q[LATENCY-1];
endmodule

// File: tb/tb_vga_text_renderer.sv
// tb/tb_vga_text_renderer.sv - directed tables and randomized stimulus against a frame-level model
module tb_vga_text_renderer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] sx, sy;
    logic        hs_in, vs_in, de_in;
    logic [6:0]  cur_x, cur_y;
    logic        cur_en;
    logic [3:0]  r, g, b;
    logic        hs, vs;

    vga_text_renderer_if mem();

    vga_text_renderer dut (
        .CLK_PIXEL (clk),
        .RESET_N   (rst_n),
        .SCREEN_X  (sx),
        .SCREEN_Y  (sy),
        .HS_IN     (hs_in),
        .VS_IN     (vs_in),
        .DE_IN     (de_in),
        .CURSOR_X  (cur_x),
        .CURSOR_Y  (cur_y),
        .CURSOR_EN (cur_en),
        .mem       (mem),
        .R         (r),
        .G         (g),
        .B         (b),
        .HS        (hs),
        .VS        (vs)
    );

    always #5 clk = ~clk;

    logic [15:0] vram [0:8191];
    logic [7:0]  font [0:2047];

    always @(posedge clk) begin
        mem.VRAM_DATA <= vram[mem.VRAM_ADDR];
        mem.FONT_DATA <= font[mem.FONT_ADDR];
    end

    logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                              12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    typedef struct {
        int x; int y; bit hs; bit vs; bit de; int cx; int cy; bit cen; int frames;
    } stim_t;

    typedef struct {
        int at; int kind; int val; string name;
    } event_t;

    typedef struct {
        int x; int y; bit de; int addr; int rgb;
    } vec_t;

    stim_t  hist [8];
    event_t ev_q [$];
    int     cyc, chk_from, frames_cnt, checks, errors;
    bit     chk_en, last_vs;
    stim_t  idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cell_addr(input int x, input int y);
        if (x / 8 < 100 && y / 8 < 75) return (y / 8) * 100 + x / 8;
        return 0;
    endfunction

    function automatic logic [11:0] pixel(input stim_t s, input int frames);
        logic [15:0] w;
        int gl;
        bit on, hit;
        w   = vram[cell_addr(s.x, s.y)];
        gl  = int'(font[int'(w[7:0]) * 8 + s.y % 8]);
        on  = ((gl >> (7 - s.x % 8)) & 1) == 1;
        hit = s.cen && (s.x / 8 == s.cx) && (s.y / 8 == s.cy) && (s.x / 8 < 100) && (s.y / 8 < 75);
        if (hit && ((frames >> 4) & 1) == 1) on = !on;
        return on ? pal[w[11:8]] : pal[w[15:12]];
    endfunction

    task automatic model_check(input int e);
        stim_t s0, s1, s2, s3, s4;
        s0 = hist[e % 8]; s1 = hist[(e - 1) % 8]; s2 = hist[(e - 2) % 8];
        s3 = hist[(e - 3) % 8]; s4 = hist[(e - 4) % 8];
        chk("vram_addr", 32'(mem.VRAM_ADDR), 32'(cell_addr(s0.x, s0.y)));
        chk("font_addr", 32'(mem.FONT_ADDR),
            32'(int'(vram[cell_addr(s2.x, s2.y)][7:0]) * 8 + s2.y % 8));
        chk("rgb", 32'({r, g, b}), s3.de ? 32'(pixel(s4, s1.frames)) : 32'd0);
        chk("hs", 32'(hs), 32'(s3.hs));
        chk("vs", 32'(vs), 32'(s3.vs));
    endtask

    task automatic push_ev(input int at, input int kind, input int val, input string name);
        event_t ev;
        ev.at = at; ev.kind = kind; ev.val = val; ev.name = name;
        ev_q.push_back(ev);
    endtask

    task automatic run_events(input int e);
        for (int i = ev_q.size() - 1; i >= 0; i--) begin
            if (ev_q[i].at == e) begin
                case (ev_q[i].kind)
                    0:       chk(ev_q[i].name, 32'(mem.VRAM_ADDR), 32'(ev_q[i].val));
                    1:       chk(ev_q[i].name, 32'({r, g, b}), 32'(ev_q[i].val));
                    default: chk(ev_q[i].name, 32'(hs), 32'(ev_q[i].val));
                endcase
                ev_q.delete(i);
            end
        end
    endtask

    // check the edge just taken, then present the stimulus for the next edge
    task automatic tick(input stim_t s_in);
        stim_t s;
        s = s_in;
        @(posedge clk);
        #1;
        if (chk_en && cyc >= chk_from) model_check(cyc);
        run_events(cyc);
        cyc++;
        if (s.vs && !last_vs) frames_cnt = (frames_cnt + 1) % 32;
        last_vs  = s.vs;
        s.frames = frames_cnt;
        hist[cyc % 8] = s;
        sx = 11'(s.x); sy = 11'(s.y);
        hs_in = s.hs; vs_in = s.vs; de_in = s.de;
        cur_x = 7'(s.cx); cur_y = 7'(s.cy); cur_en = s.cen;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        frames_cnt = 0;
        last_vs = 1'b0;
        hist[cyc % 8].frames = 0;
        chk_from = cyc + 4;
        chk_en = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        chk({tag, "_vram_addr"}, 32'(mem.VRAM_ADDR), 32'd0);
        chk({tag, "_font_addr"}, 32'(mem.FONT_ADDR), 32'd0);
        chk({tag, "_hs"}, 32'(hs), 32'd0);
        chk({tag, "_vs"}, 32'(vs), 32'd0);
    endtask

    task automatic show_pixel(input int x, input int y, input int exp, input string name);
        stim_t s;
        s = idle; s.x = x; s.y = y;
        tick(s);
        push_ev(cyc + 4, 1, exp, name);
        s = idle; s.de = 1'b1;
        tick(s);
        repeat (3) tick(idle);
    endtask

    task automatic vs_pulses(input int n);
        stim_t s;
        s = idle;
        repeat (n) begin
            s.vs = 1'b1; tick(s);
            s.vs = 1'b0; tick(s);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  vt [5];
        stim_t s;
        bit    prev_disp;
        int    rel;

        checks = 0; errors = 0; cyc = 0; chk_from = 0; chk_en = 1'b0;
        frames_cnt = 0; last_vs = 1'b0;
        for (int i = 0; i < 8192; i++) vram[i] = 16'($urandom);
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
        vram[502] = 16'hF141;               // 'A', fg 1, bg F at cell (2,5)
        vram[503] = 16'h4241;               // 'A', fg 2, bg 4 at cell (3,5)
        font[16'h41 * 8 + 2] = 8'h18;
        foreach (hist[i]) hist[i] = '{0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0};
        idle = '{900, 700, 1'b0, 1'b0, 1'b0, 2, 5, 1'b0, 0};

        // reset with busy-looking inputs
        rst_n = 1'b0;
        s = '{17, 42, 1'b1, 1'b0, 1'b1, 2, 5, 1'b1, 0};
        repeat (3) tick(s);
        check_zero("reset");
        release_reset();

        // address and render table
        vt = '{'{17, 42, 1'b1, 502, 12'hFFF},
               '{19, 42, 1'b1, 502, 12'h00A},
               '{16, 42, 1'b1, 502, 12'hFFF},
               '{799, 599, 1'b1, 7499, -1},
               '{17, 600, 1'b0, 0, 0}};
        foreach (vt[i]) begin
            s = idle; s.x = vt[i].x; s.y = vt[i].y;
            tick(s);
            push_ev(cyc, 0, vt[i].addr, "tbl_addr");
            if (vt[i].rgb >= 0) push_ev(cyc + 4, 1, vt[i].rgb, "tbl_rgb");
            s = idle; s.de = vt[i].de;
            tick(s);
            repeat (3) tick(idle);
        end

        // sync alignment: HS_IN one cycle behind X=840
        s = idle; s.x = 840; s.y = 10;
        tick(s);
        s.x = 841; s.hs = 1'b1;
        tick(s);
        push_ev(cyc + 2, 2, 0, "hs_before");
        push_ev(cyc + 3, 2, 1, "hs_rise");
        push_ev(cyc + 3, 1, 0, "rgb_blank");
        repeat (4) begin s.x++; tick(s); end
        s.hs = 1'b0;
        repeat (6) tick(s);

        // cursor blink at cell (2,5)
        idle.cen = 1'b1;
        show_pixel(19, 42, 12'h00A, "blink0_fg");
        show_pixel(16, 42, 12'hFFF, "blink0_bg");
        show_pixel(27, 42, 12'h0A0, "blink0_other");
        vs_pulses(16);
        show_pixel(19, 42, 12'hFFF, "blink1_fg");
        show_pixel(16, 42, 12'h00A, "blink1_bg");
        show_pixel(27, 42, 12'h0A0, "blink1_other");
        vs_pulses(16);
        show_pixel(19, 42, 12'h00A, "blink2_fg");
        show_pixel(16, 42, 12'hFFF, "blink2_bg");
        show_pixel(27, 42, 12'h0A0, "blink2_other");

        // randomized traffic, mostly near the cursor so hits occur
        prev_disp = 1'b0;
        for (int i = 0; i < 400; i++) begin
            s.x   = ($urandom % 2 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1055));
            s.y   = ($urandom % 2 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 627));
            s.de  = prev_disp;
            s.hs  = ($urandom % 8 == 0);
            s.vs  = ($urandom % 16 == 0);
            s.cx  = int'($urandom_range(0, 7));
            s.cy  = int'($urandom_range(0, 7));
            s.cen = ($urandom % 2 == 0);
            prev_disp = (s.x < 800) && (s.y < 600);
            tick(s);
        end

        // reset pulse during active video
        idle.cen = 1'b0;
        s = idle; s.x = 19; s.y = 42; s.de = 1'b1;
        repeat (6) tick(s);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        chk_en = 1'b0;
        repeat (2) tick(s);
        release_reset();
        rel = cyc;
        push_ev(rel, 1, 0, "refill_rgb0");
        push_ev(rel + 1, 1, 0, "refill_rgb1");
        push_ev(rel + 2, 1, 0, "refill_rgb2");
        push_ev(rel + 4, 1, 12'h00A, "refill_valid");
        repeat (10) tick(s);
        repeat (4) tick(idle);

        chk("events_drained", 32'(ev_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
